// File: rtl/codegen_sched.sv
// Round-robin scheduler sharing one codegen between NUM_REQ burst requesters.
// Grants one requester at a time, sequences the codegen and streams its codes to a valid/ready sink.
module codegen_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_limit,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic                            cg_enable,
  output logic                            cg_start,
  output logic [DATA_WIDTH-1:0]           cg_limit,
  input  logic [DATA_WIDTH-1:0]           cg_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [ID_WIDTH-1:0]             out_id,
  output logic                            out_last
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       scan_idx;
  logic [PTR_W-1:0]       sel_id;
  logic                   sel_found;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic [DATA_WIDTH-1:0]  sel_limit;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [ID_WIDTH-1:0]    id_q;
  logic [DATA_WIDTH-1:0]  limit_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   cnt_q;
  logic                   run;
  logic                   accept;

  // Search starts one past the last granted requester, so every requester waits at most one lap.
  always_comb begin
    scan_idx  = '0;
    sel_id    = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!sel_found && req[scan_idx]) begin
        sel_found = 1'b1;
        sel_id    = scan_idx;
      end
    end
    sel_len   = req_len[sel_id*LEN_WIDTH +: LEN_WIDTH];
    sel_limit = req_limit[sel_id*DATA_WIDTH +: DATA_WIDTH];
  end

  // Sink handshake: a beat transfers on a rising edge where out_valid and out_ready are both high;
  // out_valid never drops while a beat is pending, and out_data/out_id/out_last hold until it transfers.
  assign run       = (state_q == RUN);
  assign accept    = run && out_ready;
  assign busy      = (state_q != IDLE);
  assign cg_enable = run;
  assign cg_start  = accept;
  assign out_valid = run;
  assign out_data  = cg_data;
  assign out_last  = run && (cnt_q == (len_q - LEN_WIDTH'(1)));
  assign out_id    = id_q;
  assign cg_limit  = limit_q;
  assign gnt       = gnt_q;
  assign done      = (state_q == DONE) ? gnt_q : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sel_found) state_d = (sel_len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (accept && out_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      id_q    <= '0;
      limit_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            gnt_q   <= NUM_REQ'(1) << sel_id;
            id_q    <= ID_WIDTH'(sel_id);
            limit_q <= sel_limit;
            len_q   <= sel_len;
          end
        end
        RUN: begin
          if (accept) cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          gnt_q <= '0;
          ptr_q <= PTR_W'(id_q);
          cnt_q <= '0;
        end
        default: begin
          gnt_q <= '0;
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_codegen_sched.sv
// Directed bench for codegen_sched with a behavioural codegen (+73 step, wrap at limit)
// and an expected-beat queue checked on every accepted sink transfer.
module tb_codegen_sched;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int LW = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_l;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_limit;
  logic [NR*LW-1:0]  req_len;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic              busy;
  logic              cg_enable;
  logic              cg_start;
  logic [DW-1:0]     cg_limit;
  logic [DW-1:0]     cg_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_id;
  logic              out_last;

  int checks = 0;
  int errors = 0;
  int n;
  int rr_order[5] = '{0, 1, 2, 3, 0};
  logic [DW+IW:0] exp_q[$];
  logic [DW+IW:0] mon_e;

  codegen_sched #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .LEN_WIDTH(LW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_l(rst_l), .req(req), .req_limit(req_limit), .req_len(req_len),
    .gnt(gnt), .done(done), .busy(busy), .cg_enable(cg_enable), .cg_start(cg_start),
    .cg_limit(cg_limit), .cg_data(cg_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_last(out_last)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural codegen: cleared while disabled, steps +73 on start, returns to 0 after hitting limit
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l)          cg_data <= '0;
    else if (!cg_enable) cg_data <= '0;
    else if (cg_start)   cg_data <= (cg_data == cg_limit) ? '0 : cg_data + DW'(73);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] lim, input logic [LW-1:0] len);
    req[i] = 1'b1;
    req_limit[i*DW +: DW] = lim;
    req_len[i*LW +: LW]   = len;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [IW-1:0] id, input logic last);
    exp_q.push_back({last, id, d});
  endtask

  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (done != '0) begin
        cnt = k;
        break;
      end
    end
    check("done_seen", 32'(cnt != 0), 32'd1);
  endtask

  task automatic check_all_zero();
    check("z_gnt", 32'(gnt), 0);
    check("z_done", 32'(done), 0);
    check("z_busy", 32'(busy), 0);
    check("z_cg_enable", 32'(cg_enable), 0);
    check("z_cg_start", 32'(cg_start), 0);
    check("z_out_valid", 32'(out_valid), 0);
    check("z_out_last", 32'(out_last), 0);
    check("z_cg_limit", 32'(cg_limit), 0);
    check("z_out_id", 32'(out_id), 0);
  endtask

  // scoreboard: every accepted beat must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_l && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexp_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", 32'(out_data), 32'(mon_e[DW-1:0]));
        check("beat_id", 32'(out_id), 32'(mon_e[DW +: IW]));
        check("beat_last", 32'(out_last), 32'(mon_e[DW+IW]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0; req = '0; req_limit = '0; req_len = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero();
    tick(); rst_l = 1'b1;

    // single burst: 0,73,146,0,73 then done[0]
    tick(); set_req(0, 8'd146, 8'd5); out_ready = 1'b1;
    push_beat(8'd0, 2'd0, 1'b0); push_beat(8'd73, 2'd0, 1'b0); push_beat(8'd146, 2'd0, 1'b0);
    push_beat(8'd0, 2'd0, 1'b0); push_beat(8'd73, 2'd0, 1'b1);
    wait_done(20, n);
    check("single_latency", 32'(n), 32'd7);
    check("single_done", 32'(done), 32'h1);
    check("single_gnt_held", 32'(gnt), 32'h1);
    check("single_done_valid", 32'(out_valid), 0);
    tick(); req = '0;
    check("single_q_empty", 32'(exp_q.size()), 0);

    // backpressure during beat 2, req dropped mid-burst
    tick(); set_req(0, 8'd146, 8'd5);
    push_beat(8'd0, 2'd0, 1'b0); push_beat(8'd73, 2'd0, 1'b0); push_beat(8'd146, 2'd0, 1'b0);
    push_beat(8'd0, 2'd0, 1'b0); push_beat(8'd73, 2'd0, 1'b1);
    tick(); req = '0;
    tick(); out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'd73);
      check("stall_start", 32'(cg_start), 0);
    end
    tick(); out_ready = 1'b1;
    wait_done(20, n);
    check("bp_latency", 32'(n), 32'd5);
    check("bp_done", 32'(done), 32'h1);
    tick();
    check("bp_q_empty", 32'(exp_q.size()), 0);

    // zero length on requester 2
    tick(); set_req(2, 8'd9, 8'd0);
    @(negedge clk);
    check("zl_idle_valid", 32'(out_valid), 0);
    tick(); req = '0;
    @(negedge clk);
    check("zl_gnt", 32'(gnt), 32'h4);
    check("zl_done", 32'(done), 32'h4);
    check("zl_busy", 32'(busy), 32'd1);
    check("zl_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("zl_gnt_off", 32'(gnt), 0);
    check("zl_done_off", 32'(done), 0);

    // unreachable limit: modulo-256 wrap
    tick(); set_req(0, 8'd1, 8'd5);
    push_beat(8'd0, 2'd0, 1'b0); push_beat(8'd73, 2'd0, 1'b0); push_beat(8'd146, 2'd0, 1'b0);
    push_beat(8'd219, 2'd0, 1'b0); push_beat(8'd36, 2'd0, 1'b1);
    wait_done(20, n);
    check("wrap_latency", 32'(n), 32'd7);
    check("wrap_done", 32'(done), 32'h1);
    tick(); req = '0;
    check("wrap_q_empty", 32'(exp_q.size()), 0);

    // reset at beat 3 of a len=10 burst
    tick(); set_req(0, 8'd255, 8'd10);
    push_beat(8'd0, 2'd0, 1'b0); push_beat(8'd73, 2'd0, 1'b0);
    @(negedge clk);
    tick(); tick(); tick(); rst_l = 1'b0;
    #1;
    check_all_zero();
    check("rst_q_empty", 32'(exp_q.size()), 0);
    set_req(1, 8'd255, 8'd3);
    tick(); rst_l = 1'b1;
    push_beat(8'd0, 2'd0, 1'b0);   push_beat(8'd73, 2'd0, 1'b0);  push_beat(8'd146, 2'd0, 1'b0);
    push_beat(8'd219, 2'd0, 1'b0); push_beat(8'd36, 2'd0, 1'b0);  push_beat(8'd109, 2'd0, 1'b0);
    push_beat(8'd182, 2'd0, 1'b0); push_beat(8'd255, 2'd0, 1'b0); push_beat(8'd0, 2'd0, 1'b0);
    push_beat(8'd73, 2'd0, 1'b1);
    @(negedge clk);
    check("rst_idle_busy", 32'(busy), 0);
    @(negedge clk);
    check("rst_first_gnt", 32'(gnt), 32'h1);
    check("rst_first_valid", 32'(out_valid), 32'd1);
    tick(); req = '0;
    wait_done(30, n);
    check("rst_burst_len", 32'(n), 32'd10);
    check("rst_done", 32'(done), 32'h1);
    tick();
    check("rst_q_empty2", 32'(exp_q.size()), 0);

    // round-robin from reset: order 0,1,2,3,0 with 2 gap cycles
    rst_l = 1'b0;
    tick(); rst_l = 1'b1;
    tick();
    for (int i = 0; i < NR; i++) set_req(i, 8'd200, 8'd2);
    for (int b = 0; b < 5; b++) begin
      push_beat(8'd0, IW'(rr_order[b]), 1'b0);
      push_beat(8'd73, IW'(rr_order[b]), 1'b1);
    end
    @(negedge clk);
    check("rr_start_busy", 32'(busy), 0);
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      check("rr_gnt", 32'(gnt), 32'(1 << rr_order[b]));
      check("rr_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      check("rr_gnt_hold", 32'(gnt), 32'(1 << rr_order[b]));
      check("rr_last", 32'(out_last), 32'd1);
      @(negedge clk);
      check("rr_done", 32'(done), 32'(1 << rr_order[b]));
      check("rr_done_valid", 32'(out_valid), 0);
      if (b == 4) begin
        tick(); req = '0;
      end
      @(negedge clk);
      check("rr_gap_gnt", 32'(gnt), 0);
      check("rr_gap_valid", 32'(out_valid), 0);
    end
    @(negedge clk);
    check("rr_end_busy", 32'(busy), 0);
    check("rr_q_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
